sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
Shares one iterative floating-point square-root core between NUM_REQ requesters in the sphere-collision pipeline, for example the per-pair distance units. The block arbitrates round-robin, loads the operand, restarts the core through its active-low reset, waits for convergence, and returns the root to the winning requester. Zero and negative operands bypass the core. A watchdog bounds iterations that do not converge.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, maximum core RUN cycles before the result is forced out
CNT_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived; do not override)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request; held with req_data until accepted
req_data  in  32*NUM_REQ  IEEE-754 single operands; requester i uses bits [32i+31:32i]
req_ready  out  NUM_REQ  one-hot accept strobe (combinational)
rsp_valid  out  NUM_REQ  one-hot, 1-cycle result strobe to the owning requester
rsp_root  out  32  result value (IEEE-754 single)
rsp_pos  out  1  core "n >= 1" flag; 0 on bypass
rsp_timeout  out  1  qualifies rsp_valid; 1 = watchdog expired, root is last core value
busy  out  1  high in every state except IDLE
core_rst_n  out  1  active-low restart to the sqrt core
core_n  out  32  operand to the core (registered)
core_root  in  32  core root output
core_pos  in  1  core pos output
core_rdy  in  1  core out_rdy; level, stays high until the core is reset

Behaviour:
- Reset values (while RST=1 and after release):
  - State = IDLE; core_rst_n=0; core_n=0.
  - rsp_valid=0; rsp_root=0; rsp_pos=0; rsp_timeout=0; busy=0.
  - Watchdog counter = 0; priority pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - core_rst_n=0.
  - If any req_valid, the grant g is the first asserted index searching from ptr+1 upward with wrap.
  - req_ready[g]=1 in that cycle only; req_ready is 0 in every other state.
  - On the edge: core_n <= operand; ptr <= g; the block latches g.
  - Operand exponent and mantissa both zero (+0 or -0): rsp_root <= 32'h00000000, rsp_pos <= 0, go to DONE.
  - Otherwise, operand sign=1: rsp_root <= 32'h7FC00000 (quiet NaN), rsp_pos <= 0, go to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH: core_rst_n=0 for exactly one cycle; counter <= 0; go to RUN.
- RUN:
  - core_rst_n=1; counter increments each cycle.
  - core_rdy=1: capture core_root and core_pos, rsp_timeout <= 0, go to DONE.
  - Otherwise, counter == TIMEOUT_CYCLES-1: capture core_root and core_pos, rsp_timeout <= 1, go to DONE.
  - If core_rdy and timeout coincide, core_rdy wins and rsp_timeout=0.
- DONE:
  - rsp_valid[g]=1 for one cycle; rsp_root, rsp_pos and rsp_timeout are stable while rsp_valid is high and hold afterwards.
  - core_rst_n=0; go to IDLE.
  - There is no response backpressure; requesters must accept in the strobe cycle.
- Latency, measured from the accept cycle T:
  - Core path: rsp_valid at T+3+k, where k is the number of RUN cycles before core_rdy is sampled high.
  - Bypass path: rsp_valid at T+1.
  - Back-to-back throughput: one new accept per IDLE visit, so the minimum spacing is 2 cycles for bypass.
- Fairness: after granting g, g has lowest priority on the next arbitration. A requester that keeps req_valid high waits at most NUM_REQ-1 transactions.
- Invariants:
  - A requester that drops req_valid before acceptance is simply not granted.
  - req_valid changes outside IDLE are ignored.
- Reset mid-operation: RST forces IDLE immediately and asynchronously and drives core_rst_n=0. The in-flight request is dropped with no rsp_valid; requesters re-issue.
- Core visibility: core_rst_n is high only in RUN, so a stale core_rdy from a previous operation is never sampled.

Decomposition:
- Shared package (fp_pkg):
  - FP_ZERO = 32'h00000000.
  - FP_QNAN = 32'h7FC00000.
  - FP_SIGN_BIT = 31.
  - sqrt_arb_state_t enum {IDLE, LAUNCH, RUN, DONE}.
- Sub-module rr_arbiter: combinational, parameter N; inputs req[N] and ptr; outputs one-hot grant and its binary index. It is reused later by the divider and adder sharing blocks.

Test Plan:
- Single request: req 0, data 32'h40800000 (4.0); core model returns 32'h40000000 with pos=1 after 20 cycles. Expect rsp_valid=4'b0001 at T+23, root 40000000, pos 1, timeout 0.
- Contention: after reset, req_valid=4'b0101 held. Grants go 0 then 2. Then hold 4'b0011: grants go 0 then 1, not 1 twice. No two req_ready bits are ever high together.
- Bypass: req 1 with 32'h80000000 returns root 32'h00000000 at T+1 with core_rst_n never high. req 3 with 32'hC0800000 returns 32'h7FC00000, pos 0.
- Watchdog: TIMEOUT_CYCLES=16 and the core never raises core_rdy. Expect rsp_valid at T+18 with rsp_timeout=1 and root equal to the core_root value at that edge. Then check the core_rdy-on-16th-cycle tie gives timeout=0.
- Reset mid-RUN: assert RST 5 cycles into RUN. Outputs go to reset values asynchronously, no rsp_valid appears, and the next request after release is granted to requester 0.
- Stale ready: the core model holds core_rdy=1 from the previous operation. The new operation must pass through LAUNCH (core_rst_n low) and not complete before RUN.

Source files
------------

// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared IEEE-754 single-precision constants, helpers and the
//          state type used by the floating-point sharing blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h00000000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam int          FP_SIGN_BIT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sqrt_arb_state_t;

  // True for +0 and -0: exponent and mantissa both clear, sign ignored.
  function automatic logic fp_is_zero(input logic [31:0] value);
    return (value[30:0] == 31'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter. Searches upward from ptr+1
//          with wrap and returns a one-hot grant plus its binary index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Pick the first asserted request after the last winner, wrapping once.
  always_comb begin
    logic found;
    int   k;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sqrt_arbiter.sv
// ============================================================================
// Module : sqrt_arbiter
// Brief  : Shares one iterative square-root core between NUM_REQ
//          requesters. Round-robin grant, zero/negative bypass, core restart
//          through its active-low reset, and a watchdog on non-convergence.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sqrt_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_root,
  output logic                    rsp_pos,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    core_rst_n,
  output logic [31:0]             core_n,
  input  logic [31:0]             core_root,
  input  logic                    core_pos,
  input  logic                    core_rdy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sqrt_arb_state_t    state;
  sqrt_arb_state_t    state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  logic [31:0]        operand;
  logic               op_zero;
  logic               op_neg;
  logic               timeout_hit;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_req     = |req_valid;
  assign operand     = req_data[32*int'(grant_idx) +: 32];
  assign op_zero     = fp_is_zero(operand);
  assign op_neg      = operand[FP_SIGN_BIT];
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register; reset drops any in-flight operation at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: bypass operands skip the core, RUN ends on ready or watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = (op_zero || op_neg) ? DONE : LAUNCH;
        end
      end
      LAUNCH:  state_nxt = RUN;
      RUN: begin
        if (core_rdy || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: core is held in reset outside RUN so a stale ready is never seen.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    busy       = (state != IDLE);
    core_rst_n = (state == RUN);
    if (state == IDLE) begin
      req_ready = grant;
    end
    if (state == DONE) begin
      rsp_valid[owner] = 1'b1;
    end
  end

  // Datapath: latch the winner and operand, run the watchdog, capture results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr         <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      cnt         <= '0;
      core_n      <= FP_ZERO;
      rsp_root    <= FP_ZERO;
      rsp_pos     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            core_n <= operand;
            ptr    <= grant_idx;
            owner  <= grant_idx;
            if (op_zero) begin
              rsp_root    <= FP_ZERO;
              rsp_pos     <= 1'b0;
              rsp_timeout <= 1'b0;
            end else if (op_neg) begin
              rsp_root    <= FP_QNAN;
              rsp_pos     <= 1'b0;
              rsp_timeout <= 1'b0;
            end
          end
        end
        LAUNCH: begin
          cnt <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (core_rdy) begin
            rsp_root    <= core_root;
            rsp_pos     <= core_pos;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            rsp_root    <= core_root;
            rsp_pos     <= core_pos;
            rsp_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
// ============================================================================
// Module : tb_sqrt_arbiter
// Brief  : Self-checking bench for sqrt_arbiter with a behavioural core
//          model and a rule-based reference for grant, latency and result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sqrt_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic            CLK;
  logic            RST;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_root;
  logic            rsp_pos;
  logic            rsp_timeout;
  logic            busy;
  logic            core_rst_n;
  logic [31:0]     core_n;
  logic [31:0]     core_root;
  logic            core_pos;
  logic            core_rdy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [31:0] opd [N];
  int          core_lat;
  bit          core_pos_b;
  bit          stale;
  int          run_cnt  = 0;
  int          model_ptr;

  sqrt_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_root    (rsp_root),
    .rsp_pos     (rsp_pos),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .core_rst_n  (core_rst_n),
    .core_n      (core_n),
    .core_root   (core_root),
    .core_pos    (core_pos),
    .core_rdy    (core_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Core model: counts cycles out of reset, ready after core_lat run cycles.
  always @(posedge CLK) run_cnt <= core_rst_n ? run_cnt + 1 : 0;
  assign core_rdy  = stale ? 1'b1 : (core_rst_n && (run_cnt >= core_lat));
  assign core_pos  = core_pos_b;
  assign core_root = 32'h40000000 | 32'(run_cnt[15:0]);

  always_comb begin
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = opd[i];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 1; i <= N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One full transaction: offer mask, check grant, wait for and check response.
  task automatic run_txn(input logic [N-1:0] mask, input int lat, input bit pos, input bit stl);
    int          eg, t0, elat, kk;
    logic [31:0] op, eroot;
    bit          epos, etmo, byp, got;
    core_lat   = lat;
    core_pos_b = pos;
    stale      = stl;
    req_valid  = mask;
    eg         = pick(mask, model_ptr);
    got        = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      #1;
      check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready != '0) begin
        got = 1'b1;
        check("grant", 32'(req_ready), 32'd1 << eg);
      end else begin
        @(negedge CLK);
      end
    end
    if (!got) begin
      check("accept_wait", 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    t0        = cyc;
    model_ptr = eg;
    op        = opd[eg];
    if (op[30:0] == 31'd0) begin
      byp = 1; eroot = 32'h00000000; epos = 0; etmo = 0; elat = 1;
    end else if (op[31]) begin
      byp = 1; eroot = 32'h7FC00000; epos = 0; etmo = 0; elat = 1;
    end else begin
      byp   = 0;
      kk    = stl ? 0 : ((lat < TO - 1) ? lat : TO - 1);
      eroot = 32'h40000000 | 32'(kk);
      epos  = pos;
      etmo  = !stl && (lat > TO - 1);
      elat  = 3 + kk;
    end
    @(negedge CLK);
    req_valid = N'($urandom);
    #1;
    check("core_n", core_n, op);
    check("busy", 32'(busy), 32'd1);
    check("launch_rst_n", 32'(core_rst_n), 32'd0);
    got = 1'b0;
    for (int c = 1; c < TO + 8 && !got; c++) begin
      if (c > 1) begin
        @(negedge CLK);
        req_valid = N'($urandom);
        #1;
      end
      check("ready_busy", 32'(req_ready), 32'd0);
      if (byp) check("bypass_rst_n", 32'(core_rst_n), 32'd0);
      if (rsp_valid != '0) begin
        got = 1'b1;
        check("latency", 32'(cyc - t0), 32'(elat));
        check("rsp_valid", 32'(rsp_valid), 32'd1 << eg);
        check("rsp_root", rsp_root, eroot);
        check("rsp_pos", 32'(rsp_pos), 32'(epos));
        check("rsp_timeout", 32'(rsp_timeout), 32'(etmo));
      end
    end
    if (!got) check("rsp_wait", 32'd0, 32'd1);
    @(negedge CLK);
    req_valid = '0;
    #1;
    check("rsp_strobe_len", 32'(rsp_valid), 32'd0);
    check("root_hold", rsp_root, eroot);
  endtask

  task automatic do_reset();
    req_valid = '0;
    stale     = 1'b0;
    core_lat  = 100000;
    RST       = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST       = 1'b0;
    model_ptr = N - 1;
  endtask

  initial begin
    logic [N-1:0] m;
    int           sel;
    req_valid  = '0;
    for (int i = 0; i < N; i++) opd[i] = 32'h0;
    core_lat   = 100000;
    core_pos_b = 1'b0;
    stale      = 1'b0;
    model_ptr  = N - 1;
    RST        = 1'b1;

    // Reset values
    @(negedge CLK);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_n", core_n, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_root", rsp_root, 32'd0);
    check("rst_rsp_pos", 32'(rsp_pos), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Single request through the core
    opd[0] = 32'h40800000;
    run_txn(4'b0001, 20, 1'b1, 1'b0);

    // Contention: 0 then 2, then 0 then 1
    do_reset();
    opd[0] = 32'h41100000;
    opd[1] = 32'h3F800000;
    opd[2] = 32'h40400000;
    run_txn(4'b0101, 5, 1'b1, 1'b0);
    run_txn(4'b0101, 2, 1'b0, 1'b0);
    run_txn(4'b0011, 0, 1'b1, 1'b0);
    run_txn(4'b0011, 7, 1'b1, 1'b0);

    // Bypass paths: -0, negative, +0
    opd[1] = 32'h80000000;
    run_txn(4'b0010, 5, 1'b1, 1'b0);
    opd[3] = 32'hC0800000;
    run_txn(4'b1000, 5, 1'b1, 1'b0);
    opd[2] = 32'h00000000;
    run_txn(4'b0100, 5, 1'b1, 1'b0);

    // Watchdog expiry, then ready on the last allowed cycle
    opd[0] = 32'h40800000;
    run_txn(4'b0001, 100000, 1'b0, 1'b0);
    run_txn(4'b0001, TO - 1, 1'b1, 1'b0);

    // Stale ready held high from before: must still pass LAUNCH and RUN
    run_txn(4'b0001, 0, 1'b1, 1'b1);

    // Reset five cycles into RUN
    opd[2]    = 32'h40800000;
    core_lat  = 100000;
    stale     = 1'b0;
    req_valid = 4'b0100;
    #1;
    check("mid_grant", 32'(req_ready), 32'h4);
    repeat (7) @(negedge CLK);
    req_valid = '0;
    check("mid_in_run", 32'(core_rst_n), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_core_rst_n", 32'(core_rst_n), 32'd0);
    check("mid_core_n", core_n, 32'd0);
    check("mid_rsp_root", rsp_root, 32'd0);
    check("mid_rsp_pos", 32'(rsp_pos), 32'd0);
    check("mid_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST       = 1'b0;
    model_ptr = N - 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge CLK);
    end
    for (int i = 0; i < N; i++) opd[i] = 32'h40800000;
    run_txn(4'b1111, 3, 1'b1, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      opd[i] = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h0;
        else if (sel == 1) opd[i] = $urandom | 32'h80800000;
        else               opd[i] = ($urandom & 32'h7FFFFFFF) | 32'h1;
      end
      m = N'($urandom_range(1, (1 << N) - 1));
      run_txn(m, $urandom_range(0, TO + 3), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
